im_program_loader: RTL and testbench
====================================

Name: im_program_loader

Overview:
- Writer side of the instruction memory that the fetch stage reads.
- Accepts a byte stream from a host over a valid/ready handshake and writes it into instruction memory from address 0 upward.
- Holds the CPU core in reset until a complete, valid program image is loaded, then releases it.
- Sits between the host/debug link and the instruction memory write port.

Parameters:
- ADDR_W, 8, instruction memory address width. Matches the 8-bit PC.
- DATA_W, 8, instruction width in bits.
- TIMEOUT, 1024, idle cycles allowed between handshake transfers while a load is in progress. 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that begins a load
- in_data  in  8  stream byte
- in_valid  in  1  in_data is valid
- in_ready  out  1  loader accepts in_data this cycle
- im_we  out  1  instruction memory write enable
- im_addr  out  ADDR_W  write address
- im_wdata  out  DATA_W  write data
- cpu_reset_n  out  1  active-low reset to the core; 1 = core runs
- done  out  1  load completed successfully
- error  out  1  load failed (checksum or timeout)
- words_written  out  ADDR_W+1  bytes written in the current or last load

Behaviour:
- Transfer: a transfer occurs on a rising clk edge when in_valid=1 and in_ready=1. in_data must be held stable while in_valid=1 and in_ready=0.
- Reset (reset=1 at a clk edge):
  - state=IDLE; in_ready=0, im_we=0, im_addr=0, im_wdata=0.
  - cpu_reset_n=0, done=0, error=0, words_written=0.
  - Reset mid-load aborts the load; memory contents already written are left as they are.
- States:
  - IDLE: in_ready=0. start=1 -> LEN.
  - LEN: in_ready=1. Length byte L is received. Image size N=L, except L=0 means N=256. Clear the address counter and the running sum, then -> DATA.
  - DATA: in_ready=1. Each transfer writes one byte.
    - The last byte (count N) -> CHK if CHECKSUM_EN is defined, else -> DONE.
  - CHK: in_ready=1. Add the received byte to the sum.
    - Sum mod 256 == 0 -> DONE.
    - Otherwise -> ERR.
  - DONE: in_ready=0, done=1, cpu_reset_n=1. start=1 -> LEN and drives cpu_reset_n=0, done=0.
  - ERR: in_ready=0, error=1, cpu_reset_n=0. start=1 -> LEN and clears error.
- cpu_reset_n changes on the same edge as the state register. It is 1 only while the state is DONE.
- Write timing: a DATA transfer at edge t produces im_we=1, im_addr=k, im_wdata=byte on the cycle after edge t, where k = zero-based index of the byte in the image.
  - im_we is a one-cycle pulse per transfer.
  - Back-to-back transfers give consecutive addresses with no gaps.
  - im_addr and im_wdata hold their last value when im_we=0.
- words_written:
  - Increments with each im_we pulse.
  - Reaches 256 on a full image; the extra bit prevents wrap.
  - Cleared on entry to LEN.
- Address wrap: at most 256 bytes are written, so im_addr never wraps within one load.
- Running sum: 8-bit, modulo 256. Covers the length byte plus all data bytes.
- start is ignored in LEN, DATA and CHK. A start pulse that coincides with reset is ignored.
- Timeout (TIMEOUT>0):
  - In LEN, DATA and CHK, a counter counts consecutive cycles with no transfer.
  - Reaching TIMEOUT -> ERR.
  - Any transfer clears the counter.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - The CHK state exists.
  - A trailing checksum byte is required; the image is accepted only if the 8-bit sum of length byte + data + checksum is 0.
  - A mismatch -> ERR with cpu_reset_n kept at 0.
- Undefined:
  - No CHK state and no running-sum logic.
  - The last data byte goes directly to DONE, and the stream is exactly 1+N bytes.

Test Plan:
1. Reset, then start. Stream 0x03, 0x05, 0x41, 0xC2 with in_valid held high; with the checksum build also send 0xF5.
   - Required: im_we pulses at addr 0, 1, 2 with data 0x05, 0x41, 0xC2 on consecutive cycles.
   - Required: words_written=3, done=1, cpu_reset_n=1.
2. With LOADER_CHECKSUM_EN, send the same image with checksum 0xF4.
   - Required: error=1, done=0, cpu_reset_n=0; all 3 writes still occur.
3. Length byte 0x00 followed by 256 bytes of value i.
   - Required: 256 writes, last write addr 0xFF with data 0xFF, words_written=256, done=1.
4. Start, length 0x04, 2 data bytes, then in_valid=0 for TIMEOUT cycles.
   - Required: error=1 on cycle TIMEOUT, in_ready=0, cpu_reset_n=0.
5. Assert reset during DATA after 2 of 5 bytes.
   - Required: next cycle state=IDLE, all outputs at their reset values; a fresh start and full 5-byte load ends with done=1.
6. In DONE, pulse start and send a new 1-byte image 0x01, 0xAA.
   - Required: cpu_reset_n drops to 0 on the start edge; one write at addr 0 with data 0xAA; then done=1.
   - Required: start pulses during DATA have no effect.

Source files
------------

// File: rtl/im_program_loader_if.sv
// Byte-stream handshake and instruction-memory write port used by im_program_loader.
// master: host side. It drives the byte stream and observes the memory writes.
// slave : the loader. It accepts the stream and drives the memory write port.
interface im_program_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [DATA_W-1:0] im_wdata;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  im_we,
        input  im_addr,
        input  im_wdata
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output im_we,
        output im_addr,
        output im_wdata
    );
endinterface

// File: rtl/im_program_loader.sv
// Instruction-memory program loader.
// Receives a length byte followed by N image bytes over a valid/ready stream.
// It writes the image bytes to instruction memory starting at address 0.
// The CPU core is held in reset until a complete image has been accepted.
// Optional feature macro LOADER_CHECKSUM_EN enables a trailing checksum byte
// (CHK state). With this macro defined, the 8-bit sum of the length byte, the
// data bytes and the checksum must be zero for the image to be accepted.
// TIMEOUT idle cycles without a transfer during a load abort the load. A
// TIMEOUT of 0 disables the abort.
module im_program_loader #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    im_program_loader_if.slave bus,
    output logic               cpu_reset_n,
    output logic               done,
    output logic               error,
    output logic [ADDR_W:0]    words_written
);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] FULL_IMG = CNT_W'(1) << ADDR_W;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LEN, DATA, CHK, DONE, ERR} state_t;
    localparam state_t AFTER_DATA = CHK;
`else
    typedef enum logic [2:0] {IDLE, LEN, DATA, DONE, ERR} state_t;
    localparam state_t AFTER_DATA = DONE;
`endif

    state_t           state;
    state_t           state_next;
    logic             busy;
    logic             xfer;
    logic             last_byte;
    logic             enter_len;
    logic             timeout_hit;
    logic [CNT_W-1:0] len_n;

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] sum_chk;
    assign busy    = (state == LEN) || (state == DATA) || (state == CHK);
    assign sum_chk = sum + bus.in_data;
`else
    assign busy = (state == LEN) || (state == DATA);
`endif

    assign bus.in_ready = busy;
    assign xfer         = bus.in_valid && busy;
    assign last_byte    = (words_written + CNT_ONE) == len_n;
    assign enter_len    = (state_next == LEN) && (state != LEN);

    // The core runs only while a good image is resident.
    assign done        = (state == DONE);
    assign error       = (state == ERR);
    assign cpu_reset_n = (state == DONE);

    // State register. A start pulse that coincides with reset loses to reset.
    always_ff @(posedge clk) begin
        // NOTE: registers are updated with <= so every flop samples pre-edge values.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state decode. The timeout overrides every busy-state transition.
    always_comb begin
        // NOTE: default first so no path through the case leaves state_next unassigned (no latch).
        state_next = state;
        unique case (state)
            IDLE:       if (start) state_next = LEN;
            LEN:        if (xfer) state_next = DATA;
            DATA:       if (xfer && last_byte) state_next = AFTER_DATA;
`ifdef LOADER_CHECKSUM_EN
            CHK:        if (xfer) state_next = (sum_chk == '0) ? DONE : ERR;
`endif
            DONE, ERR:  if (start) state_next = LEN;
            default:    state_next = IDLE;
        endcase
        if (timeout_hit) state_next = ERR;
    end

    // Memory write port and progress counter. The write lands one cycle after its transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.im_we     <= 1'b0;
            bus.im_addr   <= '0;
            bus.im_wdata  <= '0;
            words_written <= '0;
        end else begin
            bus.im_we <= 1'b0;
            if (enter_len) words_written <= '0;
            if (state == DATA && xfer) begin
                bus.im_we     <= 1'b1;
                bus.im_addr   <= words_written[ADDR_W-1:0];
                bus.im_wdata  <= bus.in_data;
                words_written <= words_written + CNT_ONE;
            end
        end
    end

    // Image length capture. A length byte of 0 encodes a full 2^ADDR_W image.
    always_ff @(posedge clk) begin
        // NOTE: len_n (and sum) carry no reset; LEN always loads them before DATA reads them.
        if (state == LEN && xfer)
            len_n <= (bus.in_data == '0) ? FULL_IMG : CNT_W'(bus.in_data);
    end

`ifdef LOADER_CHECKSUM_EN
    // Running modulo-2^DATA_W sum over the length byte and the data bytes.
    always_ff @(posedge clk) begin
        if (xfer) begin
            if (state == LEN)       sum <= bus.in_data;
            else if (state == DATA) sum <= sum + bus.in_data;
        end
    end
`endif

    generate
        if (TIMEOUT > 0) begin : g_timeout
            localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            localparam logic [TW-1:0] LAST_IDLE = TW'(TIMEOUT - 1);
            logic [TW-1:0] idle_cnt;

            // Count consecutive stalled cycles while a load is in progress.
            always_ff @(posedge clk) begin
                if (reset || !busy || xfer) idle_cnt <= '0;
                else                        idle_cnt <= idle_cnt + TW'(1);
            end

            assign timeout_hit = busy && !xfer && (idle_cnt == LAST_IDLE);
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate
endmodule

// File: tb/tb_im_program_loader.sv
// Self-checking bench for im_program_loader.
// The bench builds each image as a byte queue and predicts the writes, the
// final flags and the byte count from the image itself.
// It exercises directed corner sequences, a table of load vectors and random loads.
module tb_im_program_loader;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int TO     = 64;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic            clk   = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            cpu_reset_n;
    logic            done;
    logic            error;
    logic [ADDR_W:0] words_written;

    im_program_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    im_program_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .bus           (bus),
        .cpu_reset_n   (cpu_reset_n),
        .done          (done),
        .error         (error),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                cyc;
    } wr_t;

    typedef struct {
        logic [7:0] len_b;
        logic [7:0] first;
        logic [7:0] step;
        bit         bad;
        int         max_gap;
        int         exp_words;
        bit         exp_done;
        bit         exp_error;
    } load_vec_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc   = 0;
    wr_t        wr_q[$];
    logic [7:0] img[$];
    load_vec_t  vecs[6];

    // Memory-side monitor: log every write with the cycle it appeared on.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.im_we === 1'b1) wr_q.push_back('{addr: bus.im_addr, data: bus.im_wdata, cyc: cyc});
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_rst(input string tag);
        check({tag, " in_ready"},      32'(bus.in_ready),  0);
        check({tag, " im_we"},         32'(bus.im_we),     0);
        check({tag, " im_addr"},       32'(bus.im_addr),   0);
        check({tag, " im_wdata"},      32'(bus.im_wdata),  0);
        check({tag, " cpu_reset_n"},   32'(cpu_reset_n),   0);
        check({tag, " done"},          32'(done),          0);
        check({tag, " error"},         32'(error),         0);
        check({tag, " words_written"}, 32'(words_written), 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one byte after an optional random idle gap and hold it until accepted.
    task automatic send_byte(input logic [7:0] b, input int max_gap, input string tag);
        int gap;
        int guard;
        bit took;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap)) : 0;
        repeat (gap) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            @(negedge clk);
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        guard = 0;
        took  = 1'b0;
        while (!took && guard < 50) begin
            took = (bus.in_ready === 1'b1);
            @(negedge clk);
            guard++;
        end
        if (!took) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s handshake: in_ready stayed 0, needed 1", tag);
        end
    endtask

    task automatic wait_end(input string tag);
        int k;
        k = 0;
        while (!(done === 1'b1 || error === 1'b1) && k < 4 * TO) begin
            @(negedge clk);
            k++;
        end
        if (!(done === 1'b1 || error === 1'b1)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s finish: done/error still 0 after %0d cycles, needed 1", tag, k);
        end
    endtask

    // Stream the image held in img, then compare the final flags and the write log.
    task automatic run_load(input logic [7:0] len_b, input bit bad, input int max_gap,
                            input int exp_words, input bit exp_done, input bit exp_error,
                            input string tag);
        logic [7:0] s;
        wr_q.delete();
        pulse_start();
        s = len_b;
        send_byte(len_b, max_gap, tag);
        for (int i = 0; i < img.size(); i++) begin
            send_byte(img[i], max_gap, tag);
            s = s + img[i];
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(bad ? (8'h00 - s - 8'h01) : (8'h00 - s), max_gap, tag);
`endif
        bus.in_valid = 1'b0;
        wait_end(tag);
        @(negedge clk);
        check({tag, " done"},          32'(done),          32'(exp_done));
        check({tag, " error"},         32'(error),         32'(exp_error));
        check({tag, " cpu_reset_n"},   32'(cpu_reset_n),   32'(exp_done));
        check({tag, " in_ready"},      32'(bus.in_ready),  0);
        check({tag, " words_written"}, 32'(words_written), 32'(exp_words));
        check({tag, " write count"},   32'(wr_q.size()),   32'(img.size()));
        for (int i = 0; i < wr_q.size() && i < img.size(); i++) begin
            check($sformatf("%s wr%0d addr", tag, i), 32'(wr_q[i].addr), 32'(i));
            check($sformatf("%s wr%0d data", tag, i), 32'(wr_q[i].data), 32'(img[i]));
            if (max_gap == 0 && i > 0)
                check($sformatf("%s wr%0d spacing", tag, i), 32'(wr_q[i].cyc - wr_q[i-1].cyc), 1);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n;
        bit  rbad;
        int  rgap;

        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check_rst("reset");
        reset = 1'b0;
        @(negedge clk);
        check("idle in_ready", 32'(bus.in_ready), 0);

        // Test 1: 3-byte image streamed back to back.
        img = '{8'h05, 8'h41, 8'hC2};
        run_load(8'h03, 1'b0, 0, 3, 1'b1, 1'b0, "t1");

        // Test 6: restart from DONE with a 1-byte image; start pulses mid-load are ignored.
        wr_q.delete();
        pulse_start();
        check("t6 start cpu_reset_n",   32'(cpu_reset_n),   0);
        check("t6 start done",          32'(done),          0);
        check("t6 start in_ready",      32'(bus.in_ready),  1);
        check("t6 start words_written", 32'(words_written), 0);
        pulse_start();
        send_byte(8'h01, 0, "t6");
        bus.in_valid = 1'b0;
        pulse_start();
        @(negedge clk);
        check("t6 start-in-data in_ready", 32'(bus.in_ready), 1);
        check("t6 start-in-data writes",   32'(wr_q.size()),  0);
        send_byte(8'hAA, 0, "t6");
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h55, 0, "t6");
`endif
        bus.in_valid = 1'b0;
        wait_end("t6");
        @(negedge clk);
        check("t6 write count", 32'(wr_q.size()), 1);
        if (wr_q.size() > 0) begin
            check("t6 wr addr", 32'(wr_q[0].addr), 0);
            check("t6 wr data", 32'(wr_q[0].data), 32'h0000_00AA);
        end
        check("t6 done",          32'(done),          1);
        check("t6 cpu_reset_n",   32'(cpu_reset_n),   1);
        check("t6 words_written", 32'(words_written), 1);

`ifdef LOADER_CHECKSUM_EN
        // Test 2: same image with a wrong checksum (0xF4).
        img = '{8'h05, 8'h41, 8'hC2};
        run_load(8'h03, 1'b1, 0, 3, 1'b0, 1'b1, "t2");
`endif

        // Test 3: length byte 0 means a full 256-byte image.
        img.delete();
        for (int i = 0; i < 256; i++) img.push_back(8'(i));
        run_load(8'h00, 1'b0, 0, 256, 1'b1, 1'b0, "t3");
        check("t3 last addr", 32'(wr_q[wr_q.size()-1].addr), 32'h0000_00FF);
        check("t3 last data", 32'(wr_q[wr_q.size()-1].data), 32'h0000_00FF);

        // Test 4: stream stalls after 2 of 4 data bytes.
        pulse_start();
        send_byte(8'h04, 0, "t4");
        send_byte(8'h11, 0, "t4");
        send_byte(8'h22, 0, "t4");
        bus.in_valid = 1'b0;
        repeat (TO - 1) @(negedge clk);
        check("t4 pre-timeout error",    32'(error),        0);
        check("t4 pre-timeout in_ready", 32'(bus.in_ready), 1);
        @(negedge clk);
        check("t4 timeout error",       32'(error),         1);
        check("t4 timeout in_ready",    32'(bus.in_ready),  0);
        check("t4 timeout cpu_reset_n", 32'(cpu_reset_n),   0);
        check("t4 timeout done",        32'(done),          0);
        check("t4 words_written",       32'(words_written), 2);

        // Test 5: reset after 2 of 5 data bytes, then reset+start together, then a clean load.
        pulse_start();
        send_byte(8'h05, 0, "t5");
        send_byte(8'h9C, 0, "t5");
        send_byte(8'h3D, 0, "t5");
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_rst("t5 abort");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("t5 start-with-reset in_ready", 32'(bus.in_ready), 0);
        img = '{8'h9C, 8'h3D, 8'h00, 8'hFF, 8'h77};
        run_load(8'h05, 1'b0, 1, 5, 1'b1, 1'b0, "t5");

        // Table-driven load vectors.
        vecs[0] = '{8'h01, 8'h7E, 8'h00, 1'b0, 0, 1,   1'b1,    1'b0};
        vecs[1] = '{8'h02, 8'h00, 8'hFF, 1'b0, 2, 2,   1'b1,    1'b0};
        vecs[2] = '{8'h10, 8'hF0, 8'h07, 1'b0, 3, 16,  1'b1,    1'b0};
        vecs[3] = '{8'h05, 8'h33, 8'h11, 1'b1, 1, 5,   !CHK_EN, CHK_EN};
        vecs[4] = '{8'h08, 8'hFF, 8'h01, 1'b1, 0, 8,   !CHK_EN, CHK_EN};
        vecs[5] = '{8'hFF, 8'h00, 8'h01, 1'b0, 0, 255, 1'b1,    1'b0};
        for (int v = 0; v < 6; v++) begin
            n = (vecs[v].len_b == 8'h00) ? 256 : int'(vecs[v].len_b);
            img.delete();
            for (int i = 0; i < n; i++) img.push_back(vecs[v].first + 8'(i) * vecs[v].step);
            run_load(vecs[v].len_b, vecs[v].bad, vecs[v].max_gap, vecs[v].exp_words,
                     vecs[v].exp_done, vecs[v].exp_error, $sformatf("vec%0d", v));
        end

        // Random loads against the image-level model.
        for (int r = 0; r < 25; r++) begin
            n    = int'($urandom_range(48, 1));
            rbad = ($urandom_range(3) == 0);
            rgap = int'($urandom_range(3));
            img.delete();
            for (int i = 0; i < n; i++) img.push_back(8'($urandom));
            run_load(8'(n), rbad, rgap, n, !(CHK_EN && rbad), CHK_EN && rbad,
                     $sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
